// File: rtl/sseg_readback_if.sv
// Seven-segment readback bus: display pins in, decoded frame and status pulses out.
// Latency: none, wiring only.
// Backpressure: none; the display side never stalls and the status pulses are fire-and-forget.
interface sseg_readback_if;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] bcd_value;
    logic [3:0]  blank_mask;
    logic        value_valid;
    logic        pattern_err;
    logic        frame_timeout;

    // display driver side
    modport master (
        output seg_n, an_n,
        input  bcd_value, blank_mask, value_valid, pattern_err, frame_timeout
    );

    // readback side
    modport slave (
        input  seg_n, an_n,
        output bcd_value, blank_mask, value_valid, pattern_err, frame_timeout
    );
endinterface

// File: rtl/sseg_readback.sv
// Decodes a multiplexed active-low 4-digit seven-segment bus back to BCD, one word per full frame.
// Latency: capture STABLE_CYCLES edges after a pattern appears at the pins; publish one edge after the 4th capture.
// Backpressure: none; frames that do not complete within TIMEOUT_CYCLES are dropped and flagged.
module sseg_readback #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           reset,
    sseg_readback_if.slave bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, QUAL, HELD} state_t;

    // pin sample S and the sample before it
    logic [6:0] s_seg, p_seg;
    logic [3:0] s_an, p_an;

    state_t        state, state_nxt;
    logic [SW-1:0] stab_cnt, stab_cnt_nxt;
    logic          restart, advance, capture;

    logic       an_ok, s_changed;
    logic [1:0] dig_idx;

    logic [3:0] dec_nib;
    logic       dec_blank, dec_err;

    logic [3:0][3:0] shadow;
    logic [3:0]      shadow_blank;
    logic [3:0]      seen, seen_nxt;
    logic [TW-1:0]   tmo_cnt, tmo_cnt_nxt;
    logic            complete, timeout_hit;

    logic [15:0] bcd_q;
    logic [3:0]  blank_q;
    logic        valid_q, err_q, tmo_q;

    assign bus.bcd_value     = bcd_q;
    assign bus.blank_mask    = blank_q;
    assign bus.value_valid   = valid_q;
    assign bus.pattern_err   = err_q;
    assign bus.frame_timeout = tmo_q;

    assign s_changed = (s_seg != p_seg) || (s_an != p_an);

    // register the pins once and keep the previous sample for stability compares
    always_ff @(posedge clk) begin
        if (reset) begin
            s_seg <= 7'h7F;
            p_seg <= 7'h7F;
            s_an  <= 4'hF;
            p_an  <= 4'hF;
        end else begin
            s_seg <= bus.seg_n;
            p_seg <= s_seg;
            s_an  <= bus.an_n;
            p_an  <= s_an;
        end
    end

    // exactly one anode low selects the digit slot; none or several is not a digit
    always_comb begin
        an_ok   = 1'b1;
        dig_idx = 2'd0;
        case (s_an)
            4'b1110: dig_idx = 2'd0;
            4'b1101: dig_idx = 2'd1;
            4'b1011: dig_idx = 2'd2;
            4'b0111: dig_idx = 2'd3;
            default: an_ok = 1'b0;
        endcase
    end

    // segment pattern back to BCD; all-dark is a blank digit, anything else unknown is an error
    always_comb begin
        dec_nib   = 4'hE;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (s_seg)
            7'b1000000: dec_nib = 4'd0;
            7'b1111001: dec_nib = 4'd1;
            7'b0100100: dec_nib = 4'd2;
            7'b0110000: dec_nib = 4'd3;
            7'b0011001: dec_nib = 4'd4;
            7'b0010010: dec_nib = 4'd5;
            7'b0000010: dec_nib = 4'd6;
            7'b1111000: dec_nib = 4'd7;
            7'b0000000: dec_nib = 4'd8;
            7'b0010000: dec_nib = 4'd9;
            7'b1111111: begin
                dec_nib   = 4'hF;
                dec_blank = 1'b1;
            end
            default: dec_err = 1'b1;
        endcase
    end

    // qualification FSM state and stability counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            stab_cnt <= '0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_cnt_nxt;
        end
    end

    // next state: restart on any change of a valid digit, count identical samples, capture once
    always_comb begin
        state_nxt    = state;
        stab_cnt_nxt = stab_cnt;
        restart      = 1'b0;
        advance      = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (an_ok) restart = 1'b1;
            end
            QUAL: begin
                if (!an_ok)         state_nxt = IDLE;
                else if (s_changed) restart   = 1'b1;
                else                advance   = 1'b1;
            end
            HELD: begin
                if (!an_ok)         state_nxt = IDLE;
                else if (s_changed) restart   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (restart) begin
            stab_cnt_nxt = SW'(1);
            state_nxt    = QUAL;
        end
        if (advance && stab_cnt != STABLE_MAX) begin
            stab_cnt_nxt = stab_cnt + SW'(1);
        end
        if ((restart || advance) && stab_cnt_nxt == STABLE_MAX) begin
            capture   = 1'b1;
            state_nxt = HELD;
        end
    end

    // frame bookkeeping: completion takes priority over timeout in the same cycle
    always_comb begin
        complete    = (seen == 4'b1111);
        timeout_hit = !complete && (seen != 4'b0000) && (tmo_cnt == TMO_LAST);
        seen_nxt    = (complete || timeout_hit) ? 4'b0000 : seen;
        if (capture) seen_nxt[dig_idx] = 1'b1;
        if (seen == 4'b0000 || complete || timeout_hit) tmo_cnt_nxt = '0;
        else if (tmo_cnt != TMO_MAX)                     tmo_cnt_nxt = tmo_cnt + TW'(1);
        else                                             tmo_cnt_nxt = tmo_cnt;
    end

    // shadow capture, frame publish and single-cycle status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow       <= '0;
            shadow_blank <= 4'b0000;
            seen         <= 4'b0000;
            tmo_cnt      <= '0;
            bcd_q        <= 16'h0000;
            blank_q      <= 4'b0000;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            valid_q <= complete;
            tmo_q   <= timeout_hit;
            err_q   <= capture && dec_err;
            if (complete) begin
                bcd_q   <= shadow;
                blank_q <= shadow_blank;
            end
            if (capture) begin
                shadow[dig_idx]       <= dec_nib;
                shadow_blank[dig_idx] <= dec_blank;
            end
            seen    <= seen_nxt;
            tmo_cnt <= tmo_cnt_nxt;
        end
    end
endmodule
